// File: rtl/screen_mux_ctl.sv
// PONG video-path top: selects one screen pipeline, registers its VGA signals and owns
// the menu-driven screen, difficulty and palette state. Screen changes apply at vblank rise.
module screen_mux_ctl #(
    parameter int N_SRC     = 4,
    parameter int GAME_IDX  = 1,
    parameter int CRED_IDX  = 2,
    parameter int N_DIFF    = 2,
    parameter int N_PAL     = 7,
    parameter int BTN_X0    = 362,
    parameter int BTN_X1    = 674,
    parameter int BTN_Y0    = 46,
    parameter int BTN_PITCH = 192,
    parameter int BTN_H     = 100
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_SRC-1:0]     src_vsync,
    input  logic [N_SRC-1:0]     src_hsync,
    input  logic [12*N_SRC-1:0]  src_rgb,
    input  logic                 vblnk_in,
    input  logic [11:0]          xpos,
    input  logic [11:0]          ypos,
    input  logic                 mouse_left,
    input  logic                 back_btn,
    output logic                 vsync_out,
    output logic                 hsync_out,
    output logic [11:0]          rgb_out,
    output logic [2:0]           screen_sel,
    output logic [3:0]           difficulty,
    output logic [11:0]          color1,
    output logic [11:0]          color2,
    output logic                 switch_pend
);

    typedef enum logic {S_IDLE, S_PEND} state_t;

    state_t      state, state_nxt;
    logic        mouse_prev, back_prev, vb_prev;
    logic        click, back, vb_rise;
    logic        x_in;
    logic [3:0]  hit;
    logic [2:0]  target, target_nxt;
    logic [2:0]  sel_nxt;
    logic [3:0]  diff_nxt;
    logic [2:0]  pal_idx, pal_nxt;
    logic [11:0] pal_c1, pal_c2;
    logic [11:0] mux_rgb;
    logic        mux_vs, mux_hs;

    assign click   = mouse_left & ~mouse_prev;
    assign back    = back_btn & ~back_prev;
    assign vb_rise = vblnk_in & ~vb_prev;

    always_comb begin
        switch_pend = (state == S_PEND);
    end

    // Button boxes are inclusive on all four edges.
    always_comb begin
        hit  = '0;
        x_in = (xpos >= 12'(BTN_X0)) && (xpos <= 12'(BTN_X1));
        for (int unsigned k = 0; k < 4; k++) begin
            hit[k] = x_in
                  && (ypos >= 12'(BTN_Y0 + k * BTN_PITCH))
                  && (ypos <= 12'(BTN_Y0 + k * BTN_PITCH + BTN_H));
        end
    end

    always_comb begin
        mux_rgb = '0;
        mux_vs  = 1'b0;
        mux_hs  = 1'b0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (screen_sel == 3'(i)) begin
                mux_rgb = src_rgb[12*i +: 12];
                mux_vs  = src_vsync[i];
                mux_hs  = src_hsync[i];
            end
        end
    end

    always_comb begin
        pal_c1 = 12'h000;
        pal_c2 = 12'hFFF;
        case (pal_idx)
            3'd1: begin pal_c1 = 12'h099; pal_c2 = 12'hF66; end
            3'd2: begin pal_c1 = 12'h909; pal_c2 = 12'h6F6; end
            3'd3: begin pal_c1 = 12'h990; pal_c2 = 12'h66F; end
            3'd4: begin pal_c1 = 12'h009; pal_c2 = 12'hFF6; end
            3'd5: begin pal_c1 = 12'h900; pal_c2 = 12'h6FF; end
            3'd6: begin pal_c1 = 12'h090; pal_c2 = 12'hF6F; end
            default: begin pal_c1 = 12'h000; pal_c2 = 12'hFFF; end
        endcase
    end

    // Vblank is only observed while pending, so a request raised on a vb_rise cycle waits a frame.
    always_comb begin
        state_nxt  = state;
        target_nxt = target;
        sel_nxt    = screen_sel;
        diff_nxt   = difficulty;
        pal_nxt    = pal_idx;
        case (state)
            S_IDLE: begin
                if (click && screen_sel == 3'd0) begin
                    if (hit[0]) begin
                        target_nxt = 3'(GAME_IDX);
                        state_nxt  = S_PEND;
                    end else if (hit[1]) begin
                        diff_nxt = (difficulty == 4'(N_DIFF - 1)) ? '0 : difficulty + 4'd1;
                    end else if (hit[2]) begin
                        pal_nxt = (pal_idx == 3'(N_PAL - 1)) ? '0 : pal_idx + 3'd1;
                    end else if (hit[3]) begin
                        target_nxt = 3'(CRED_IDX);
                        state_nxt  = S_PEND;
                    end
                end else if (back && screen_sel != 3'd0) begin
                    target_nxt = '0;
                    state_nxt  = S_PEND;
                end
            end
            S_PEND: begin
                if (vb_rise) begin
                    sel_nxt   = target;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mouse_prev <= 1'b1;
            back_prev  <= 1'b1;
            vb_prev    <= 1'b1;
            target     <= '0;
            screen_sel <= '0;
            difficulty <= '0;
            pal_idx    <= '0;
            color1     <= 12'h000;
            color2     <= 12'hFFF;
            vsync_out  <= 1'b0;
            hsync_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            mouse_prev <= mouse_left;
            back_prev  <= back_btn;
            vb_prev    <= vblnk_in;
            target     <= target_nxt;
            screen_sel <= sel_nxt;
            difficulty <= diff_nxt;
            pal_idx    <= pal_nxt;
            color1     <= pal_c1;
            color2     <= pal_c2;
            vsync_out  <= mux_vs;
            hsync_out  <= mux_hs;
            rgb_out    <= mux_rgb;
        end
    end

endmodule

// File: tb/tb_screen_mux_ctl.sv
// Directed bench for screen_mux_ctl: menu clicks, palette/difficulty stepping, back button,
// vblank-synchronised screen switching and the registered output mux.
module tb_screen_mux_ctl;

    logic        clk;
    logic        rst;
    logic [3:0]  src_vsync;
    logic [3:0]  src_hsync;
    logic [47:0] src_rgb;
    logic        vblnk_in;
    logic [11:0] xpos, ypos;
    logic        mouse_left;
    logic        back_btn;
    logic        vsync_out, hsync_out;
    logic [11:0] rgb_out;
    logic [2:0]  screen_sel;
    logic [3:0]  difficulty;
    logic [11:0] color1, color2;
    logic        switch_pend;

    int checks   = 0;
    int failures = 0;

    screen_mux_ctl #(
        .N_SRC(4),
        .GAME_IDX(1),
        .CRED_IDX(2),
        .N_DIFF(2),
        .N_PAL(7)
    ) dut (
        .clk(clk),
        .rst(rst),
        .src_vsync(src_vsync),
        .src_hsync(src_hsync),
        .src_rgb(src_rgb),
        .vblnk_in(vblnk_in),
        .xpos(xpos),
        .ypos(ypos),
        .mouse_left(mouse_left),
        .back_btn(back_btn),
        .vsync_out(vsync_out),
        .hsync_out(hsync_out),
        .rgb_out(rgb_out),
        .screen_sel(screen_sel),
        .difficulty(difficulty),
        .color1(color1),
        .color2(color2),
        .switch_pend(switch_pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic click_at(input logic [11:0] x, input logic [11:0] y);
        xpos = x;
        ypos = y;
        mouse_left = 1'b1;
        tick(1);
        mouse_left = 1'b0;
        tick(1);
    endtask

    task automatic back_pulse();
        back_btn = 1'b1;
        tick(1);
        back_btn = 1'b0;
        tick(1);
    endtask

    logic [11:0] exp_c1 [8] = '{12'h099, 12'h909, 12'h990, 12'h009, 12'h900, 12'h090, 12'h000, 12'h099};
    logic [11:0] exp_c2 [8] = '{12'hF66, 12'h6F6, 12'h66F, 12'hFF6, 12'h6FF, 12'hF6F, 12'hFFF, 12'hF66};

    initial begin
        src_rgb    = {12'h333, 12'h222, 12'h111, 12'hABC};
        src_vsync  = 4'b0101;
        src_hsync  = 4'b0011;
        rst        = 1'b1;
        vblnk_in   = 1'b0;
        back_btn   = 1'b0;
        xpos       = 12'd500;
        ypos       = 12'd288;
        mouse_left = 1'b1;
        tick(3);

        check("rst_sel",   32'(screen_sel), 32'd0);
        check("rst_diff",  32'(difficulty), 32'd0);
        check("rst_pend",  32'(switch_pend), 32'd0);
        check("rst_c1",    32'(color1), 32'h000);
        check("rst_c2",    32'(color2), 32'hFFF);
        check("rst_rgb",   32'(rgb_out), 32'h000);
        check("rst_vs",    32'(vsync_out), 32'd0);
        check("rst_hs",    32'(hsync_out), 32'd0);

        // mouse held high through reset release on btn1
        rst = 1'b0;
        tick(3);
        check("hold_rst_diff", 32'(difficulty), 32'd0);
        check("menu_rgb",      32'(rgb_out), 32'hABC);
        check("menu_vs",       32'(vsync_out), 32'd1);
        check("menu_hs",       32'(hsync_out), 32'd1);
        mouse_left = 1'b0;
        tick(1);

        for (int i = 0; i < 8; i++) begin
            click_at(12'd500, 12'd480);
            check($sformatf("pal_c1_%0d", i + 1), 32'(color1), 32'(exp_c1[i]));
            check($sformatf("pal_c2_%0d", i + 1), 32'(color2), 32'(exp_c2[i]));
        end

        xpos = 12'd500;
        ypos = 12'd288;
        mouse_left = 1'b1;
        tick(1000);
        mouse_left = 1'b0;
        tick(1);
        check("hold_diff", 32'(difficulty), 32'd1);
        click_at(12'd500, 12'd288);
        check("diff_wrap", 32'(difficulty), 32'd0);
        click_at(12'd500, 12'd238);
        check("diff_edge_y", 32'(difficulty), 32'd1);

        click_at(12'd361, 12'd100);
        click_at(12'd675, 12'd100);
        click_at(12'd500, 12'd147);
        check("gap_pend", 32'(switch_pend), 32'd0);
        check("gap_sel",  32'(screen_sel), 32'd0);
        check("gap_diff", 32'(difficulty), 32'd1);
        check("gap_c1",   32'(color1), 32'h099);

        click_at(12'd500, 12'd100);
        check("game_pend", 32'(switch_pend), 32'd1);
        check("game_sel_wait", 32'(screen_sel), 32'd0);
        click_at(12'd500, 12'd480);
        check("pend_ignores_click", 32'(color1), 32'h099);
        vblnk_in = 1'b1;
        tick(1);
        check("game_sel", 32'(screen_sel), 32'd1);
        check("game_pend_clr", 32'(switch_pend), 32'd0);
        check("game_rgb_lag", 32'(rgb_out), 32'hABC);
        vblnk_in = 1'b0;
        tick(1);
        check("game_rgb", 32'(rgb_out), 32'h111);
        check("game_vs",  32'(vsync_out), 32'd0);
        check("game_hs",  32'(hsync_out), 32'd1);
        check("game_diff_held", 32'(difficulty), 32'd1);
        check("game_c2_held",   32'(color2), 32'hF66);

        back_pulse();
        check("back_pend", 32'(switch_pend), 32'd1);
        back_pulse();
        check("back2_pend", 32'(switch_pend), 32'd1);
        check("back2_sel",  32'(screen_sel), 32'd1);
        vblnk_in = 1'b1;
        tick(1);
        vblnk_in = 1'b0;
        check("back_sel",  32'(screen_sel), 32'd0);
        check("back_pend_clr", 32'(switch_pend), 32'd0);
        tick(1);
        check("back_rgb", 32'(rgb_out), 32'hABC);
        back_pulse();
        check("menu_back_ignored", 32'(switch_pend), 32'd0);

        // credits click lands on the same cycle as a vblank rise
        xpos = 12'd362;
        ypos = 12'd622;
        mouse_left = 1'b1;
        vblnk_in = 1'b1;
        tick(1);
        check("cred_pend", 32'(switch_pend), 32'd1);
        check("cred_sel_wait", 32'(screen_sel), 32'd0);
        mouse_left = 1'b0;
        vblnk_in = 1'b0;
        tick(2);
        check("cred_sel_wait2", 32'(screen_sel), 32'd0);
        vblnk_in = 1'b1;
        tick(1);
        vblnk_in = 1'b0;
        check("cred_sel", 32'(screen_sel), 32'd2);
        tick(1);
        check("cred_rgb", 32'(rgb_out), 32'h222);
        check("cred_vs",  32'(vsync_out), 32'd1);
        check("cred_hs",  32'(hsync_out), 32'd0);

        back_pulse();
        check("mid_pend", 32'(switch_pend), 32'd1);
        rst = 1'b1;
        tick(1);
        check("midrst_pend", 32'(switch_pend), 32'd0);
        check("midrst_sel",  32'(screen_sel), 32'd0);
        check("midrst_diff", 32'(difficulty), 32'd0);
        check("midrst_c1",   32'(color1), 32'h000);
        check("midrst_c2",   32'(color2), 32'hFFF);
        rst = 1'b0;
        tick(2);
        check("post_rst_rgb", 32'(rgb_out), 32'hABC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
